calc_ctrl: RTL
==============

// Module: calc_ctrl
// PURPOSE
//  Control unit for the calculator datapath. Accepts keypad codes over a valid/ready handshake.
//  Sequences the datapath's operand registers and ALU select: drives ldX/ldY/clrX/clrY, s, Xin, Yin.
//  Sits between keypad scanner and datapath; Z feeds the display directly and is not read here.
// PARAMETERS
//  DIVZ_CHECK  1  1: '/' with Y==0 on '=' enters S_ERR; 0: passed to datapath unchecked
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  key_valid  in   1  keypad code present; held until accepted
//  key_code   in   4  0x0-0x9 digit, 0xA '+', 0xB '-', 0xC '*', 0xD '/', 0xE '=', 0xF clear
//  key_ready  out  1  controller can accept a key this cycle
//  ldX, ldY   out  1  one-cycle load pulses to the datapath X/Y registers
//  clrX, clrY out  1  one-cycle clear pulses to the datapath X/Y registers
//  Xin, Yin   out  4  operand digit for X/Y; meaningful only while the matching ld pulse is high
//  s          out  3  ALU select: 000 add, 001 sub, 010 mul, 011 div, 100 pass X, 101 pass Y
//  err        out  1  divide-by-zero indication; high while in S_ERR
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=S_X, op=add, y_zero=1, s=100, key_ready=1; all pulses, err, Xin, Yin = 0.
//  Handshake:
//   - Key accepted on the edge where key_valid && key_ready.
//   - key_ready=0 for exactly the next cycle (settle), then returns to 1.
//   - key_valid held across the settle cycle is accepted once only; the key must drop and reassert.
//  Latency, key accepted at edge N:
//   - Registered outputs (pulses, Xin/Yin, s, err) valid during cycle N+1.
//   - Datapath registers update at edge N+1; Z valid in cycle N+2. Pulses are one cycle wide.
//  States and transitions (keys not listed are ignored, state unchanged):
//   - S_X   : digit d -> ldX, Xin=d, s=100, stay. op key -> latch op, s=100, go S_OP. '=' -> stay.
//   - S_OP  : digit d -> ldY, Yin=d, y_zero=(d==0), s=101, go S_Y. op key -> replace op, stay.
//   - S_Y   : digit d -> reload Y as in S_OP, stay. op key -> ignored (no chaining).
//             '=' -> if DIVZ_CHECK && op==div && y_zero: s=100, err=1, go S_ERR;
//                    else s=op, go S_RES.
//   - S_RES : s holds op. digit d -> clrY, ldX, Xin=d, s=100, go S_X (new calculation).
//             op key -> keep X, latch new op, clrY, s=100, go S_OP. '=' -> stay.
//   - S_ERR : err=1; only clear is honoured.
//   - Any state, clear 0xF -> clrX+clrY pulse, op=add, s=100, err=0, go S_X; overrides all else.
//  Arithmetic: digits loaded raw (4 bits, 0-9). No width or range checks here.
//   - Subtraction wrap and division semantics belong to the datapath.
//  Reset mid-operation: returns to reset values immediately; pending pulses are dropped.
//  s and ld pulses never change in the same cycle as a clear pulse except as listed above.
// STRUCTURE
//  Package calc_pkg:
//   - key code localparams (KEY_D0..KEY_CLR), ALU select codes (SEL_ADD..SEL_PASSY),
//     state encoding (S_X, S_OP, S_Y, S_RES, S_ERR).
//  Sub-module calc_key_if: handshake, settle cycle, one-shot accept pulse plus registered code.
//  Top level: FSM plus registered output decode only.
// TESTING
//  1. keys 3,+,4,= -> ldX Xin=3 s=100; ldY Yin=4 s=101; s=000; datapath Z=7.
//  2. keys 8,/,0,= (DIVZ_CHECK=1) -> err=1, s=100, Z=8; then 0xF -> clrX,clrY, err=0, S_X.
//  3. keys 9,*,9,= then 5 -> s=010, Z=81; then clrY+ldX Xin=5, s=100, Z=5.
//  4. key_valid held 4 cycles with code 2 -> exactly one ldX; key_ready low 1 cycle after accept.
//  5. keys 6,-, then rst_n low mid-cycle -> all outputs reset asynchronously, state S_X, s=100.
//  6. keys 7,+,-,2,= -> op replaced, s=001, Z=5; op key in S_Y ignored (no pulse, s stays 101).

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator controller: keypad codes, ALU selects,
// FSM state encoding and small key-decoding helpers.
package calc_pkg;

    localparam logic [3:0] KEY_D0  = 4'h0;
    localparam logic [3:0] KEY_D9  = 4'h9;
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [2:0] SEL_ADD   = 3'b000;
    localparam logic [2:0] SEL_SUB   = 3'b001;
    localparam logic [2:0] SEL_MUL   = 3'b010;
    localparam logic [2:0] SEL_DIV   = 3'b011;
    localparam logic [2:0] SEL_PASSX = 3'b100;
    localparam logic [2:0] SEL_PASSY = 3'b101;

    typedef enum logic [2:0] {
        S_X   = 3'd0,
        S_OP  = 3'd1,
        S_Y   = 3'd2,
        S_RES = 3'd3,
        S_ERR = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        KC_DIGIT = 2'd0,
        KC_OP    = 2'd1,
        KC_EQUAL = 2'd2,
        KC_CLEAR = 2'd3
    } key_class_e;

    // Codes 0xA-0xD are operators; anything above 9 that is not an operator is '=' or clear.
    function automatic key_class_e classify_key(input logic [3:0] code);
        key_class_e kc;
        if (code inside {[KEY_D0:KEY_D9]}) begin
            kc = KC_DIGIT;
        end else if (code == KEY_EQ) begin
            kc = KC_EQUAL;
        end else if (code == KEY_CLR) begin
            kc = KC_CLEAR;
        end else begin
            kc = KC_OP;
        end
        return kc;
    endfunction

    function automatic logic [2:0] op_to_sel(input logic [3:0] code);
        logic [2:0] sel;
        case (code)
            KEY_SUB: sel = SEL_SUB;
            KEY_MUL: sel = SEL_MUL;
            KEY_DIV: sel = SEL_DIV;
            default: sel = SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/calc_key_if.sv
// Keypad handshake: one accept per key press, a one-cycle settle after each
// accept, and re-arming only once key_valid has dropped.
module calc_key_if (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid,
    output logic key_ready,
    output logic key_accept
);

    logic settle_q, settle_d;
    logic armed_q, armed_d;

    assign key_ready  = ~settle_q;
    assign key_accept = key_valid & ~settle_q & armed_q;

    // A key still held after its settle cycle must not be taken twice.
    always_comb begin
        settle_d = key_accept;
        armed_d  = key_accept ? 1'b0 : (armed_q | ~key_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator control unit: sequences datapath operand loads/clears and the ALU
// select from accepted keypad codes. All datapath-facing outputs are registered.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter bit DIVZ_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       ldX,
    output logic       ldY,
    output logic       clrX,
    output logic       clrY,
    output logic [3:0] Xin,
    output logic [3:0] Yin,
    output logic [2:0] s,
    output logic       err
);

    logic       key_accept;
    key_class_e key_class;
    logic       div_zero;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       y_zero_q, y_zero_d;

    logic       ld_x_q, ld_x_d;
    logic       ld_y_q, ld_y_d;
    logic       clr_x_q, clr_x_d;
    logic       clr_y_q, clr_y_d;
    logic [3:0] x_in_q, x_in_d;
    logic [3:0] y_in_q, y_in_d;
    logic [2:0] s_q, s_d;
    logic       err_q, err_d;

    calc_key_if u_key_if (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_accept (key_accept)
    );

    assign key_class = classify_key(key_code);
    assign div_zero  = DIVZ_CHECK && (op_q == SEL_DIV) && y_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_X;
            op_q     <= SEL_ADD;
            y_zero_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            y_zero_q <= y_zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        y_zero_d = y_zero_q;
        if (key_accept) begin
            if (key_class == KC_CLEAR) begin
                state_d  = S_X;
                op_d     = SEL_ADD;
                y_zero_d = 1'b1;
            end else begin
                case (state_q)
                    S_X: begin
                        if (key_class == KC_OP) begin
                            op_d    = op_to_sel(key_code);
                            state_d = S_OP;
                        end
                    end
                    S_OP: begin
                        if (key_class == KC_DIGIT) begin
                            y_zero_d = (key_code == KEY_D0);
                            state_d  = S_Y;
                        end else if (key_class == KC_OP) begin
                            op_d = op_to_sel(key_code);
                        end
                    end
                    S_Y: begin
                        if (key_class == KC_DIGIT) begin
                            y_zero_d = (key_code == KEY_D0);
                        end else if (key_class == KC_EQUAL) begin
                            state_d = div_zero ? S_ERR : S_RES;
                        end
                    end
                    S_RES: begin
                        // Y is cleared on leaving the result, so it reads as zero again.
                        if (key_class == KC_DIGIT) begin
                            y_zero_d = 1'b1;
                            state_d  = S_X;
                        end else if (key_class == KC_OP) begin
                            op_d     = op_to_sel(key_code);
                            y_zero_d = 1'b1;
                            state_d  = S_OP;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    always_comb begin
        ld_x_d  = 1'b0;
        ld_y_d  = 1'b0;
        clr_x_d = 1'b0;
        clr_y_d = 1'b0;
        x_in_d  = 4'd0;
        y_in_d  = 4'd0;
        s_d     = s_q;
        err_d   = (state_d == S_ERR);
        if (key_accept) begin
            if (key_class == KC_CLEAR) begin
                clr_x_d = 1'b1;
                clr_y_d = 1'b1;
                s_d     = SEL_PASSX;
            end else begin
                case (state_q)
                    S_X: begin
                        if (key_class == KC_DIGIT) begin
                            ld_x_d = 1'b1;
                            x_in_d = key_code;
                            s_d    = SEL_PASSX;
                        end else if (key_class == KC_OP) begin
                            s_d = SEL_PASSX;
                        end
                    end
                    S_OP, S_Y: begin
                        if (key_class == KC_DIGIT) begin
                            ld_y_d = 1'b1;
                            y_in_d = key_code;
                            s_d    = SEL_PASSY;
                        end else if (key_class == KC_EQUAL && state_q == S_Y) begin
                            s_d = div_zero ? SEL_PASSX : op_q;
                        end
                    end
                    S_RES: begin
                        if (key_class == KC_DIGIT) begin
                            clr_y_d = 1'b1;
                            ld_x_d  = 1'b1;
                            x_in_d  = key_code;
                            s_d     = SEL_PASSX;
                        end else if (key_class == KC_OP) begin
                            clr_y_d = 1'b1;
                            s_d     = SEL_PASSX;
                        end
                    end
                    default: begin
                        s_d = s_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_x_q  <= 1'b0;
            ld_y_q  <= 1'b0;
            clr_x_q <= 1'b0;
            clr_y_q <= 1'b0;
            x_in_q  <= 4'd0;
            y_in_q  <= 4'd0;
            s_q     <= SEL_PASSX;
            err_q   <= 1'b0;
        end else begin
            ld_x_q  <= ld_x_d;
            ld_y_q  <= ld_y_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            x_in_q  <= x_in_d;
            y_in_q  <= y_in_d;
            s_q     <= s_d;
            err_q   <= err_d;
        end
    end

    assign ldX  = ld_x_q;
    assign ldY  = ld_y_q;
    assign clrX = clr_x_q;
    assign clrY = clr_y_q;
    assign Xin  = x_in_q;
    assign Yin  = y_in_q;
    assign s    = s_q;
    assign err  = err_q;

endmodule
